// File: rtl/lcd_digit_formatter_pkg.sv
// Shared types and constants for the LCD digit formatter.
package lcd_digit_pkg;

    localparam int unsigned NUM_CHAN    = 8;
    localparam logic [7:0]  ASCII_ZERO  = 8'h30;
    localparam logic [7:0]  ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

    typedef logic [2:0] chan_t;

    // Double-dabble correction: a nibble >= 5 would overflow past 9 after the shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/lcd_digit_formatter_if.sv
// Sample input handshake and update notification of the LCD digit formatter.
interface lcd_digit_formatter_if #(
    parameter int unsigned IN_W = 8
);
    import lcd_digit_pkg::*;

    logic            in_valid;
    logic            in_ready;
    chan_t           in_chan;
    logic [IN_W-1:0] in_value;
    logic            upd_valid;
    chan_t           upd_chan;

    // Sample source / update consumer.
    modport master (
        output in_valid, in_chan, in_value,
        input  in_ready, upd_valid, upd_chan
    );

    // The formatter itself.
    modport slave (
        input  in_valid, in_chan, in_value,
        output in_ready, upd_valid, upd_chan
    );

endinterface

// File: rtl/lcd_digit_formatter_bin2bcd_seq.sv
// Serial double-dabble binary to 3-digit BCD converter, one bit per clock.
// done is high in the cycle whose clock edge performs the final shift; the
// hundreds/tens/ones outputs are valid after that edge and hold until the next start.
module bin2bcd_seq
    import lcd_digit_pkg::*;
#(
    parameter int unsigned IN_W = 8
) (
    input  logic            clk_50,
    input  logic            rst,
    input  logic            start,
    input  logic [IN_W-1:0] value,
    output logic            done,
    output logic [3:0]      hundreds,
    output logic [3:0]      tens,
    output logic [3:0]      ones
);

    localparam int unsigned CNT_W = $clog2(IN_W + 1);

    logic [IN_W-1:0]  val_q, val_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [11:0]      bcd_adj;

    // Next-state: load on start, otherwise adjust-then-shift while busy.
    always_comb begin
        val_d   = val_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        bcd_adj = {dd_adjust(bcd_q[11:8]), dd_adjust(bcd_q[7:4]), dd_adjust(bcd_q[3:0])};
        done    = busy_q && (cnt_q == CNT_W'(IN_W - 1));
        if (start) begin
            val_d  = value;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d = {bcd_adj[10:0], val_q[IN_W-1]};
            val_d = val_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    // Conversion state registers.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            val_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            val_q  <= val_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign hundreds = bcd_q[11:8];
    assign tens     = bcd_q[7:4];
    assign ones     = bcd_q[3:0];

endmodule

// File: rtl/lcd_digit_formatter.sv
// Converts per-channel binary samples to ASCII tens/ones bytes for the LCD.
// Optional build macro LCD_DIGIT_BLANK_EN: a zero tens digit shows as a space.
module lcd_digit_formatter
    import lcd_digit_pkg::*;
#(
    parameter int unsigned IN_W     = 8,
    parameter logic [7:0]  OVF_CHAR = 8'h2D
) (
    input  logic                  clk_50,
    input  logic                  rst,
    lcd_digit_formatter_if.slave  bus,
    output logic [7:0]            tens_1,
    output logic [7:0]            ones_1,
    output logic [7:0]            tens_2,
    output logic [7:0]            ones_2,
    output logic [7:0]            tens_3,
    output logic [7:0]            ones_3,
    output logic [7:0]            tens_4,
    output logic [7:0]            ones_4,
    output logic [7:0]            tens_11,
    output logic [7:0]            ones_11,
    output logic [7:0]            tens_21,
    output logic [7:0]            ones_21,
    output logic [7:0]            tens_31,
    output logic [7:0]            ones_31,
    output logic [7:0]            tens_41,
    output logic [7:0]            ones_41
);

`ifdef LCD_DIGIT_BLANK_EN
    localparam logic [7:0] TENS_RST = ASCII_SPACE;
`else
    localparam logic [7:0] TENS_RST = ASCII_ZERO;
`endif

    state_e     state_q, state_d;
    chan_t      chan_q, chan_d;
    logic       start;
    logic       wr_en;
    logic       core_done;
    logic [3:0] core_hundreds, core_tens, core_ones;
    logic [7:0] tens_byte, ones_byte;
    logic       upd_valid_q;
    chan_t      upd_chan_q;
    logic [7:0] tens_q [NUM_CHAN];
    logic [7:0] ones_q [NUM_CHAN];

    bin2bcd_seq #(
        .IN_W (IN_W)
    ) u_bin2bcd (
        .clk_50   (clk_50),
        .rst      (rst),
        .start    (start),
        .value    (bus.in_value),
        .done     (core_done),
        .hundreds (core_hundreds),
        .tens     (core_tens),
        .ones     (core_ones)
    );

    // Ready is forced low during reset so nothing is accepted on a reset edge.
    assign bus.in_ready = (state_q == IDLE) && !rst;

    // FSM next-state and control strobes.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        start   = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    start   = 1'b1;
                    chan_d  = bus.in_chan;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (core_done) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                wr_en   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and latched channel.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q <= IDLE;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
        end
    end

    // ASCII formatting of the finished conversion.
    always_comb begin
        tens_byte = ASCII_ZERO + {4'h0, core_tens};
        ones_byte = ASCII_ZERO + {4'h0, core_ones};
        if (core_hundreds != 4'd0) begin
            tens_byte = OVF_CHAR;
            ones_byte = OVF_CHAR;
        end
`ifdef LCD_DIGIT_BLANK_EN
        else if (core_tens == 4'd0) begin
            tens_byte = ASCII_SPACE;
        end
`endif
    end

    // Output byte registers and update pulse; only the addressed channel is written.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                tens_q[i] <= TENS_RST;
                ones_q[i] <= ASCII_ZERO;
            end
            upd_valid_q <= 1'b0;
            upd_chan_q  <= '0;
        end else begin
            upd_valid_q <= wr_en;
            if (wr_en) begin
                tens_q[chan_q] <= tens_byte;
                ones_q[chan_q] <= ones_byte;
                upd_chan_q     <= chan_q;
            end
        end
    end

    assign bus.upd_valid = upd_valid_q;
    assign bus.upd_chan  = upd_chan_q;

    assign tens_1  = tens_q[0];
    assign ones_1  = ones_q[0];
    assign tens_2  = tens_q[1];
    assign ones_2  = ones_q[1];
    assign tens_3  = tens_q[2];
    assign ones_3  = ones_q[2];
    assign tens_4  = tens_q[3];
    assign ones_4  = ones_q[3];
    assign tens_11 = tens_q[4];
    assign ones_11 = ones_q[4];
    assign tens_21 = tens_q[5];
    assign ones_21 = ones_q[5];
    assign tens_31 = tens_q[6];
    assign ones_31 = ones_q[6];
    assign tens_41 = tens_q[7];
    assign ones_41 = ones_q[7];

endmodule

// File: tb/tb_lcd_digit_formatter.sv
// Scoreboard bench for lcd_digit_formatter: the driver queues expected updates,
// a negedge monitor checks every upd_valid pulse against the queue and a byte model.
module tb_lcd_digit_formatter;
    import lcd_digit_pkg::*;

`ifdef LCD_DIGIT_BLANK_EN
    localparam logic [7:0] TZ = 8'h20;
`else
    localparam logic [7:0] TZ = 8'h30;
`endif
    localparam logic [7:0] OVF = 8'h2D;

    logic clk_50 = 1'b0;
    logic rst    = 1'b1;
    always #10 clk_50 = ~clk_50;

    lcd_digit_formatter_if #(.IN_W(8)) bus ();

    logic [7:0] tens [8];
    logic [7:0] ones [8];

    lcd_digit_formatter #(
        .IN_W     (8),
        .OVF_CHAR (OVF)
    ) dut (
        .clk_50  (clk_50),
        .rst     (rst),
        .bus     (bus.slave),
        .tens_1  (tens[0]), .ones_1  (ones[0]),
        .tens_2  (tens[1]), .ones_2  (ones[1]),
        .tens_3  (tens[2]), .ones_3  (ones[2]),
        .tens_4  (tens[3]), .ones_4  (ones[3]),
        .tens_11 (tens[4]), .ones_11 (ones[4]),
        .tens_21 (tens[5]), .ones_21 (ones[5]),
        .tens_31 (tens[6]), .ones_31 (ones[6]),
        .tens_41 (tens[7]), .ones_41 (ones[7])
    );

    typedef struct {
        chan_t      chan;
        logic [7:0] t;
        logic [7:0] o;
        int         acc;
    } exp_t;

    exp_t       sb [$];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    logic [7:0] mt [8];
    logic [7:0] mo [8];

    always @(posedge clk_50) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mt[i] = TZ;
            mo[i] = 8'h30;
        end
    endtask

    task automatic check_all_bytes(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s bytes ch%0d", tag, i), {16'h0, tens[i], ones[i]},
                  {16'h0, mt[i], mo[i]});
        end
    endtask

    // Monitor: every update pulse must match the oldest queued expectation.
    always @(negedge clk_50) begin
        if (bus.upd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected upd_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("upd_chan", {29'h0, bus.upd_chan}, {29'h0, e.chan});
                check("upd latency", cyc - e.acc, 32'd9);
                mt[e.chan] = e.t;
                mo[e.chan] = e.o;
                check_all_bytes("upd");
            end
        end
    end

    // Present a sample and hold it until accepted; returns the accept cycle.
    task automatic send(input chan_t c, input logic [7:0] v, input logic [7:0] t,
                        input logic [7:0] o, input bit expect_upd, output int acc);
        int n;
        @(negedge clk_50);
        bus.in_valid = 1'b1;
        bus.in_chan  = c;
        bus.in_value = v;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk_50);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            check("accept timeout", 32'd0, 32'd1);
            acc = -1;
        end else begin
            @(posedge clk_50);
            #1;
            acc = cyc;
            if (expect_upd) sb.push_back('{chan: c, t: t, o: o, acc: acc});
        end
    endtask

    task automatic idle();
        @(negedge clk_50);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk_50);
            n++;
        end
        if (sb.size() != 0) check("drain timeout", sb.size(), 32'd0);
        repeat (2) @(negedge clk_50);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3;
        bus.in_valid = 1'b0;
        bus.in_chan  = '0;
        bus.in_value = '0;
        model_reset();

        // Reset: 3 cycles high, ready must stay low meanwhile.
        repeat (3) begin
            @(negedge clk_50);
            check("in_ready during rst", {31'h0, bus.in_ready}, 32'd0);
        end
        @(posedge clk_50);
        #1 rst = 1'b0;
        @(negedge clk_50);
        check("in_ready after rst", {31'h0, bus.in_ready}, 32'd1);
        check("upd_valid after rst", {31'h0, bus.upd_valid}, 32'd0);
        check("upd_chan after rst", {29'h0, bus.upd_chan}, 32'd0);
        check_all_bytes("reset");

        // Normal conversion.
        send(3'd2, 8'd57, 8'h35, 8'h37, 1'b1, a1);
        idle();
        drain();

        // Upper channel and boundaries.
        send(3'd7, 8'd99, 8'h39, 8'h39, 1'b1, a1);
        idle();
        drain();
        send(3'd4, 8'd0, TZ, 8'h30, 1'b1, a1);
        idle();
        drain();
        send(3'd1, 8'd9, TZ, 8'h39, 1'b1, a1);
        idle();
        drain();

        // Overflow.
        send(3'd0, 8'd100, OVF, OVF, 1'b1, a1);
        idle();
        drain();
        send(3'd0, 8'd255, OVF, OVF, 1'b1, a1);
        idle();
        drain();

        // Backpressure: in_valid stays high with new data while busy.
        send(3'd3, 8'd12, 8'h31, 8'h32, 1'b1, a1);
        send(3'd6, 8'd10, 8'h31, 8'h30, 1'b1, a2);
        send(3'd5, 8'd86, 8'h38, 8'h36, 1'b1, a3);
        idle();
        check("bp spacing 1", a2 - a1, 32'd10);
        check("bp spacing 2", a3 - a2, 32'd10);
        drain();

        // Mid-conversion reset at SHIFT edge 4.
        send(3'd5, 8'd42, 8'h34, 8'h32, 1'b0, a1);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk_50);
        #1 rst = 1'b1;
        @(posedge clk_50);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk_50);
        check("in_ready after abort", {31'h0, bus.in_ready}, 32'd1);
        check_all_bytes("abort");
        repeat (12) @(negedge clk_50);
        send(3'd5, 8'd42, 8'h34, 8'h32, 1'b1, a1);
        idle();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
